// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer: FSM states, default sizes and
// the command record carried through the command FIFO.
package shift_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_W-1:0] data;
    logic [2:0]       shamt;
    logic             lr;
    logic             al;
    logic [1:0]       rep;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// In-order command queue of DEPTH entries (power of two), element type T.
// Handshake: push_data is written on any rising edge where
// push_valid && push_ready; push_ready is low only when full, and a pop in
// the same cycle does not open room for a push (no bypass). pop is ignored
// when empty. head is the oldest entry and is valid whenever !empty.
module cmd_fifo
  import shift_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_valid,
  output logic push_ready,
  input  T     push_data,
  input  logic pop,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           push_fire;
  logic           pop_fire;

  assign push_ready = (count_q != FULL_CNT);
  assign empty      = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer that queues shift commands and drives an external
// combinational barrel shifter for 1..4 passes per command.
// Handshakes: a command transfers on a rising edge with cmd_valid &&
// cmd_ready; a result transfers on a rising edge with res_valid &&
// res_ready, and res_data/res_zero stay stable while res_valid is high.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_data,
  input  logic [2:0]   cmd_shamt,
  input  logic         cmd_lr,
  input  logic         cmd_al,
  input  logic [1:0]   cmd_rep,
  output logic [W-1:0] sh_din,
  output logic [2:0]   sh_shamt,
  output logic         sh_lr,
  output logic         sh_al,
  input  logic [W-1:0] sh_dout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_zero,
  output logic         busy,
  output state_e       dbg_state
);

  typedef struct packed {
    logic [W-1:0] data;
    logic [2:0]   shamt;
    logic         lr;
    logic         al;
    logic [1:0]   rep;
  } cmd_w_t;

  cmd_w_t       push_cmd;
  cmd_w_t       head;
  logic         fifo_empty;
  logic         pop;

  state_e       state_q, state_d;
  logic [W-1:0] work_q, work_d;
  logic [2:0]   shamt_q, shamt_d;
  logic         lr_q, lr_d;
  logic         al_q, al_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] res_data_q, res_data_d;

  assign push_cmd = '{data: cmd_data, shamt: cmd_shamt, lr: cmd_lr,
                      al: cmd_al, rep: cmd_rep};

  cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_w_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (cmd_valid),
    .push_ready (cmd_ready),
    .push_data  (push_cmd),
    .pop        (pop),
    .empty      (fifo_empty),
    .head       (head)
  );

  // Next-state logic: IDLE pops and latches, SHIFT iterates passes
  // through the external shifter, HOLD presents the result.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    shamt_d    = shamt_q;
    lr_d       = lr_q;
    al_d       = al_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          work_d  = head.data;
          shamt_d = head.shamt;
          lr_d    = head.lr;
          al_d    = head.al;
          cnt_d   = head.rep;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = sh_dout;
        if (cnt_q == 2'd0) begin
          res_data_d = sh_dout;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      shamt_q    <= '0;
      lr_q       <= 1'b0;
      al_q       <= 1'b0;
      cnt_q      <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      shamt_q    <= shamt_d;
      lr_q       <= lr_d;
      al_q       <= al_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
    end
  end

  assign sh_din    = work_q;
  assign sh_shamt  = shamt_q;
  assign sh_lr     = lr_q;
  assign sh_al     = al_q;
  assign res_valid = (state_q == HOLD);
  assign res_data  = res_data_q;
  assign res_zero  = (res_data_q == '0);
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural barrel shifter.
module tb_shift_seq_ctrl;
  import shift_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_data;
  logic [2:0]   cmd_shamt;
  logic         cmd_lr;
  logic         cmd_al;
  logic [1:0]   cmd_rep;
  logic [W-1:0] sh_din;
  logic [2:0]   sh_shamt;
  logic         sh_lr;
  logic         sh_al;
  logic [W-1:0] sh_dout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_zero;
  logic         busy;
  state_e       dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   shamt;
    logic         lr;
    logic         al;
    logic [1:0]   rep;
    logic [W-1:0] exp_res;
  } vec_t;

  vec_t vecs[9];

  shift_seq_ctrl #(.W(W), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_shamt (cmd_shamt),
    .cmd_lr    (cmd_lr),
    .cmd_al    (cmd_al),
    .cmd_rep   (cmd_rep),
    .sh_din    (sh_din),
    .sh_shamt  (sh_shamt),
    .sh_lr     (sh_lr),
    .sh_al     (sh_al),
    .sh_dout   (sh_dout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational barrel shifter
  always_comb begin
    if (sh_lr)      sh_dout = sh_din << sh_shamt;
    else if (sh_al) sh_dout = $signed(sh_din) >>> sh_shamt;
    else            sh_dout = sh_din >> sh_shamt;
  end

  // Reference result: one shift per pass, rep+1 passes.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [2:0] s,
                                             input logic lr, input logic al, input logic [1:0] rep);
    logic [W-1:0] v;
    v = d;
    for (int p = 0; p <= int'(rep); p++) begin
      if (lr)      v = v << s;
      else if (al) v = $signed(v) >>> s;
      else         v = v >> s;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input logic [W-1:0] d, input logic [2:0] s, input logic lr,
                         input logic al, input logic [1:0] rep);
    cmd_data  = d;
    cmd_shamt = s;
    cmd_lr    = lr;
    cmd_al    = al;
    cmd_rep   = rep;
  endtask

  // Offer one command until accepted (bounded); returns after the accepting edge.
  task automatic send_cmd(input logic [W-1:0] d, input logic [2:0] s, input logic lr,
                          input logic al, input logic [1:0] rep, output logic ok);
    set_cmd(d, s, lr, al, rep);
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for res_valid; returns edges waited.
  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    logic ok;
    int   n;
    int   seen;
    logic rdy;
    logic [W-1:0] exp_v;

    vecs[0] = '{8'h96, 3'd3, 1'b1, 1'b0, 2'd0, 8'hB0};
    vecs[1] = '{8'h96, 3'd2, 1'b0, 1'b1, 2'd0, 8'hE5};
    vecs[2] = '{8'h80, 3'd1, 1'b0, 1'b0, 2'd3, 8'h08};
    vecs[3] = '{8'hFF, 3'd7, 1'b1, 1'b0, 2'd1, 8'h00};
    vecs[4] = '{8'h96, 3'd4, 1'b0, 1'b0, 2'd0, 8'h09};
    vecs[5] = '{8'h81, 3'd1, 1'b1, 1'b1, 2'd1, 8'h04};
    vecs[6] = '{8'h5A, 3'd0, 1'b0, 1'b1, 2'd2, 8'h5A};
    vecs[7] = '{8'h80, 3'd7, 1'b0, 1'b1, 2'd0, 8'hFF};
    vecs[8] = '{8'h90, 3'd3, 1'b0, 1'b1, 2'd1, 8'hFE};

    // Reset
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    set_cmd('0, '0, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_data", res_data, 0);
    check("rst_sh_din", sh_din, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single commands into an idle DUT
    for (int i = 0; i < 9; i++) begin
      set_cmd(vecs[i].data, vecs[i].shamt, vecs[i].lr, vecs[i].al, vecs[i].rep);
      cmd_valid = 1'b1;
      rdy = cmd_ready;
      check($sformatf("v%0d_ready", i), rdy, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_res(n);
      check($sformatf("v%0d_latency", i), n, 2 + int'(vecs[i].rep));
      check($sformatf("v%0d_data", i), res_data, vecs[i].exp_res);
      check($sformatf("v%0d_zero", i), res_zero, (vecs[i].exp_res == '0));
      check($sformatf("v%0d_busy", i), busy, 1);
      @(posedge clk); #1;
      check($sformatf("v%0d_hold_stable", i), res_data, vecs[i].exp_res);
      take_res();
      check($sformatf("v%0d_drop", i), res_valid, 0);
      check($sformatf("v%0d_idle", i), busy, 0);
    end

    // Backpressure: six back-to-back offers with res_ready low
    for (int i = 0; i < 6; i++) begin
      set_cmd(8'h11 * (i + 1), 3'(i + 1), i[0], i[1], 2'(i % 3));
      cmd_valid = 1'b1;
      rdy = cmd_ready;
      check($sformatf("full_ready%0d", i), rdy, (i < 5));
      if (rdy) exp_q.push_back(ref_shift(cmd_data, cmd_shamt, cmd_lr, cmd_al, cmd_rep));
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_res(n);
    check("full_first_valid", res_valid, 1);
    exp_v = exp_q.pop_front();
    check("full_res0", res_data, exp_v);
    check("full_still_full", cmd_ready, 0);
    take_res();
    seen = 0;
    for (int k = 0; k < 2 && !cmd_ready; k++) begin
      @(posedge clk); #1;
    end
    check("full_ready_after_pop", cmd_ready, 1);
    for (int r = 1; r < 5; r++) begin
      wait_res(n);
      check($sformatf("full_valid%0d", r), res_valid, 1);
      exp_v = exp_q.pop_front();
      check($sformatf("full_res%0d", r), res_data, exp_v);
      take_res();
      check($sformatf("full_bubble%0d", r), res_valid, 0);
    end
    check("full_q_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("full_busy_end", busy, 0);

    // Mid-operation reset with queued commands
    send_cmd(8'hC3, 3'd1, 1'b0, 1'b0, 2'd3, ok);
    check("mr_acc0", ok, 1);
    send_cmd(8'h3C, 3'd2, 1'b1, 1'b0, 2'd0, ok);
    send_cmd(8'h0F, 3'd1, 1'b0, 1'b1, 2'd0, ok);
    check("mr_in_shift", 32'(dbg_state), 32'(SHIFT));
    rst_n = 1'b0;
    #2;
    check("mr_rst_valid", res_valid, 0);
    check("mr_rst_busy", busy, 0);
    check("mr_rst_ready", cmd_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mr_rel_busy", busy, 0);
    check("mr_rel_ready", cmd_ready, 1);
    res_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (res_valid) seen++;
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    check("mr_no_result", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
